// File: rtl/audio_record_buffer.sv
// Purpose: record/playback sample store between codec parallel side and DAC mux, with 2-bit volume on readout.
// Latency: control pins 3 clk to state change; play_out valid 2 clk after a sample_req strobe.
// Backpressure: none; strobes arriving in a state that does not use them are dropped. Loop playback: AUDIO_RECORD_LOOP_EN.
module audio_record_buffer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_record,
    input  logic              i_playback,
    input  logic [1:0]        i_volume_ctrl,
    input  logic              i_sample_end,
    input  logic              i_sample_req,
    input  logic [DATA_W-1:0] i_rec_in,
    output logic [DATA_W-1:0] o_play_out,
    output logic [ADDR_W:0]   o_rec_length,
    output logic              o_recording,
    output logic              o_playing,
    output logic              o_full
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic                      r_rec_s1, r_rec_s2, r_rec_prev;
    logic                      r_pb_s1,  r_pb_s2,  r_pb_prev;
    logic                      w_rec_rise, w_rec_fall, w_pb_rise, w_pb_fall;

    logic [DATA_W-1:0]         r_mem [DEPTH];
    logic [DATA_W-1:0]         r_rd_data;
    logic                      r_rd_vld;

    logic [ADDR_W-1:0]         r_wr_ptr;
    logic [ADDR_W-1:0]         r_rd_ptr;
    logic [ADDR_W:0]           r_rec_length;
    logic                      r_full;
    logic                      r_recording;
    logic                      r_playing;
    logic [DATA_W-1:0]         r_play_out;

    logic                      w_wr_en;
    logic                      w_rd_en;
    logic                      w_rd_last;
    logic                      w_enter_rec;
    logic                      w_enter_play;
    logic                      w_fill;
    logic                      w_play_keep;
    logic [1:0]                w_shift;
    logic signed [DATA_W-1:0]  w_scaled;

`ifndef AUDIO_RECORD_LOOP_EN
    // Set once the final read of a single-shot pass is in flight.
    logic                      r_last_pend;
`endif

    assign w_rec_rise = r_rec_s2 & ~r_rec_prev;
    assign w_rec_fall = ~r_rec_s2 & r_rec_prev;
    assign w_pb_rise  = r_pb_s2 & ~r_pb_prev;
    assign w_pb_fall  = ~r_pb_s2 & r_pb_prev;

    // The read that ends a pass is the one at the last valid stored location.
    assign w_rd_last  = ({1'b0, r_rd_ptr} == (r_rec_length - (ADDR_W+1)'(1)));

    // Attenuation: unity at volume 3, divide by 8 at volume 0, sign preserved.
    assign w_shift    = 2'd3 - i_volume_ctrl;
    assign w_scaled   = $signed(r_rd_data) >>> w_shift;

    // Two-flop synchronisers plus edge registers for the raw switch inputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rec_s1   <= 1'b0;
            r_rec_s2   <= 1'b0;
            r_rec_prev <= 1'b0;
            r_pb_s1    <= 1'b0;
            r_pb_s2    <= 1'b0;
            r_pb_prev  <= 1'b0;
        end else begin
            r_rec_s1   <= i_record;
            r_rec_s2   <= r_rec_s1;
            r_rec_prev <= r_rec_s2;
            r_pb_s1    <= i_playback;
            r_pb_s2    <= r_pb_s1;
            r_pb_prev  <= r_pb_s2;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_enter_rec  = 1'b0;
        w_enter_play = 1'b0;
        w_fill       = 1'b0;
        w_play_keep  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rec_rise) begin
                    w_state_nxt = ST_REC;
                    w_enter_rec = 1'b1;
                end else if (w_pb_rise && (r_rec_length != '0)) begin
                    w_state_nxt  = ST_PLAY;
                    w_enter_play = 1'b1;
                end
            end
            ST_REC: begin
                if (i_sample_end) begin
                    w_wr_en = 1'b1;
                    if (&r_wr_ptr) begin
                        w_fill      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                if (w_rec_fall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (w_rec_rise) begin
                    w_state_nxt = ST_REC;
                    w_enter_rec = 1'b1;
                end else if (w_pb_fall) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_play_keep = 1'b1;
`ifdef AUDIO_RECORD_LOOP_EN
                    if (i_sample_req) begin
                        w_rd_en = 1'b1;
                    end
`else
                    if (r_last_pend) begin
                        w_state_nxt = ST_IDLE;
                    end else if (i_sample_req) begin
                        w_rd_en = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, status flags and record/playback pointers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_recording  <= 1'b0;
            r_playing    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rec_length <= '0;
            r_full       <= 1'b0;
            r_rd_vld     <= 1'b0;
`ifndef AUDIO_RECORD_LOOP_EN
            r_last_pend  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_recording <= (w_state_nxt == ST_REC);
            r_playing   <= (w_state_nxt == ST_PLAY);
            r_rd_vld    <= w_rd_en;

            if (w_enter_rec) begin
                r_wr_ptr     <= '0;
                r_rec_length <= '0;
                r_full       <= 1'b0;
            end else if (w_wr_en) begin
                r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
                r_rec_length <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
                if (w_fill) begin
                    r_full <= 1'b1;
                end
            end

            if (w_enter_play) begin
                r_rd_ptr <= '0;
            end else if (w_rd_en) begin
`ifdef AUDIO_RECORD_LOOP_EN
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + ADDR_W'(1);
`else
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
`endif
            end

`ifndef AUDIO_RECORD_LOOP_EN
            if (w_state_nxt != ST_PLAY) begin
                r_last_pend <= 1'b0;
            end else if (w_rd_en && w_rd_last) begin
                r_last_pend <= 1'b1;
            end
`endif
        end
    end

    // Sample RAM: one write port, one registered read port, no reset so it maps to block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_rec_in;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Output stage: scaled sample when a read lands in PLAY, silence whenever not playing.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_play_out <= '0;
        end else if (w_play_keep) begin
            if (r_rd_vld) begin
                r_play_out <= w_scaled;
            end
        end else begin
            r_play_out <= '0;
        end
    end

    assign o_play_out   = r_play_out;
    assign o_rec_length = r_rec_length;
    assign o_recording  = r_recording;
    assign o_playing    = r_playing;
    assign o_full       = r_full;

endmodule

// File: tb/tb_audio_record_buffer.sv
// Purpose: directed + randomized bench for audio_record_buffer at depth 16 against a queue-free array model.
// Latency: checks are taken 1 time unit after the rising clock edge.
// Backpressure: not applicable; strobes are spaced far enough for the read pipeline to drain.
module tb_audio_record_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        record;
    logic        playback;
    logic [1:0]  volume_ctrl;
    logic        sample_end;
    logic        sample_req;
    logic [15:0] rec_in;
    logic [15:0] play_out;
    logic [4:0]  rec_length;
    logic        recording;
    logic        playing;
    logic        full;

    int checks = 0;
    int errors = 0;

    // Reference model: what has been stored and what playback should return.
    int exp_mem [16];
    int exp_len  = 0;
    bit exp_full = 1'b0;
    bit m_rec    = 1'b0;
    bit m_play   = 1'b0;
    int m_rd     = 0;

    always #5 clk = ~clk;

    audio_record_buffer #(.ADDR_W(4), .DATA_W(16)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_record      (record),
        .i_playback    (playback),
        .i_volume_ctrl (volume_ctrl),
        .i_sample_end  (sample_end),
        .i_sample_req  (sample_req),
        .i_rec_in      (rec_in),
        .o_play_out    (play_out),
        .o_rec_length  (rec_length),
        .o_recording   (recording),
        .o_playing     (playing),
        .o_full        (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Volume as division by 2^(3-vol), rounding toward minus infinity.
    function automatic int scale(input int s16, input int vol);
        int s;
        int d;
        int q;
        s = (s16 >= 32768) ? s16 - 65536 : s16;
        d = 1 << (3 - vol);
        q = s / d;
        if (s < 0 && q * d != s) q = q - 1;
        return q & 32'hFFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec_sample(input logic [15:0] d);
        rec_in     = d;
        sample_end = 1'b1;
        tick();
        sample_end = 1'b0;
        if (m_rec) begin
            exp_mem[exp_len] = int'(d);
            exp_len++;
            if (exp_len == 16) begin
                exp_full = 1'b1;
                m_rec    = 1'b0;
            end
        end
        chk("rec_length_after_write", rec_length, exp_len);
        chk("recording_after_write", recording, m_rec);
        tick();
    endtask

    task automatic set_record(input bit v);
        record = v;
        tick();
        tick();
        chk("record_pin_latency", recording, m_rec);
        tick();
        if (v) begin
            m_rec    = 1'b1;
            m_play   = 1'b0;
            exp_len  = 0;
            exp_full = 1'b0;
        end else begin
            m_rec = 1'b0;
        end
        chk("recording", recording, m_rec);
        chk("rec_length", rec_length, exp_len);
        chk("full", full, exp_full);
    endtask

    task automatic set_play(input bit v);
        playback = v;
        tick();
        tick();
        chk("playback_pin_latency", playing, m_play);
        tick();
        if (v) begin
            if (!m_rec && exp_len != 0) begin
                m_play = 1'b1;
                m_rd   = 0;
            end
        end else begin
            m_play = 1'b0;
        end
        chk("playing", playing, m_play);
        chk("play_out_silent", play_out, 0);
    endtask

    task automatic play_req(input logic [1:0] vol);
        int e;
        e           = 0;
        volume_ctrl = vol;
        sample_req  = 1'b1;
        tick();
        sample_req  = 1'b0;
        tick();
        if (m_play) begin
            e = scale(exp_mem[m_rd], int'(vol));
            m_rd++;
            if (m_rd == exp_len) begin
`ifdef AUDIO_RECORD_LOOP_EN
                m_rd = 0;
`else
                m_play = 1'b0;
`endif
            end
        end
        chk("play_out", play_out, e);
        chk("playing_after_req", playing, m_play);
        tick();
        chk("play_out_next", play_out, m_play ? e : 0);
    endtask

    initial begin
        int n;
        logic [15:0] first;

        reset_n     = 1'b0;
        record      = 1'b0;
        playback    = 1'b0;
        volume_ctrl = 2'd3;
        sample_end  = 1'b0;
        sample_req  = 1'b0;
        rec_in      = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("reset_play_out", play_out, 0);
        chk("reset_rec_length", rec_length, 0);
        chk("reset_recording", recording, 0);
        chk("reset_playing", playing, 0);
        chk("reset_full", full, 0);

        // Asynchronous reset in the middle of a recording.
        set_record(1'b1);
        for (int i = 0; i < 5; i++) rec_sample(16'($urandom));
        #2;
        reset_n = 1'b0;
        record  = 1'b0;
        #1;
        m_rec = 1'b0; m_play = 1'b0; exp_len = 0; exp_full = 1'b0;
        chk("async_reset_recording", recording, 0);
        chk("async_reset_rec_length", rec_length, 0);
        chk("async_reset_full", full, 0);
        chk("async_reset_playing", playing, 0);
        chk("async_reset_play_out", play_out, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // Playback with nothing stored is ignored.
        set_play(1'b1);
        set_play(1'b0);

        // Six samples, then single-shot playback with two extra requests.
        set_record(1'b1);
        for (int i = 1; i <= 6; i++) rec_sample(16'(i));
        set_record(1'b0);
        set_play(1'b1);
        for (int i = 0; i < 8; i++) play_req(2'd3);
        set_play(1'b0);

        // Volume extremes on full-scale values.
        set_record(1'b1);
        rec_sample(16'h8000);
        rec_sample(16'h7FF8);
        set_record(1'b0);
        set_play(1'b1);
        play_req(2'd0);
        play_req(2'd0);
        set_play(1'b0);
        set_play(1'b1);
        play_req(2'd1);
        play_req(2'd1);
        set_play(1'b0);

        // Random content and volumes.
        n = int'($urandom_range(3, 10));
        set_record(1'b1);
        for (int i = 0; i < n; i++) rec_sample(16'($urandom));
        set_record(1'b0);
        set_play(1'b1);
        for (int i = 0; i < n; i++) play_req(2'($urandom_range(0, 3)));
        set_play(1'b0);

        // Abort mid-playback, then restart from the first sample.
        set_play(1'b1);
        play_req(2'd3);
        play_req(2'd2);
        set_play(1'b0);
        set_play(1'b1);
        play_req(2'd3);
        set_play(1'b0);

        // Overfill: 20 strobes into 16 locations.
        set_record(1'b1);
        first = 16'($urandom);
        rec_sample(first);
        for (int i = 1; i < 20; i++) rec_sample(16'($urandom));
        set_record(1'b0);
        set_play(1'b1);
        play_req(2'd3);
        set_play(1'b0);

        // Record and playback rising together: record wins and length restarts.
        set_record(1'b1);
        for (int i = 1; i <= 6; i++) rec_sample(16'(i * 3));
        set_record(1'b0);
        record   = 1'b1;
        playback = 1'b1;
        tick();
        tick();
        tick();
        m_rec = 1'b1; exp_len = 0; exp_full = 1'b0;
        chk("both_rise_recording", recording, 1);
        chk("both_rise_playing", playing, 0);
        chk("both_rise_rec_length", rec_length, 0);
        playback = 1'b0;
        set_record(1'b0);

        // Three samples, seven requests: wraps when looping, silence otherwise.
        set_record(1'b1);
        for (int i = 1; i <= 3; i++) rec_sample(16'(i));
        set_record(1'b0);
        set_play(1'b1);
        for (int i = 0; i < 7; i++) play_req(2'd3);
        set_play(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
